// File: rtl/bsg_ver_chain_pkg.sv
// Shared types and sizing helpers for the vertical link retime chain.
package bsg_ver_chain_pkg;

  typedef enum logic {
    e_dir_ns = 1'b0,
    e_dir_sn = 1'b1
  } dir_e;

  localparam int stall_cnt_width_gp = 32;

  // At least one bit so the passthrough build still has a legal occupancy port.
  function automatic int occ_width(input int num_stages);
    int w;
    w = $clog2(2 * num_stages + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bsg_ver_chain_stage.sv
// One 2-entry elastic hop (two_fifo style): ready = !full, valid = !empty.
module bsg_ver_chain_stage
  import bsg_ver_chain_pkg::*;
  #(parameter int width_p = 64)
  (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_and_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_and_i
  );

  logic [1:0][width_p-1:0] mem_r;
  logic wr_ptr_r, rd_ptr_r, full_r, empty_r;
  logic enq, deq;

  // Handshakes are held off while reset is asserted so nothing moves during reset.
  assign ready_and_o = reset_n_i & ~full_r;
  assign v_o         = reset_n_i & ~empty_r;
  assign data_o      = mem_r[rd_ptr_r];
  assign enq         = v_i & ready_and_o;
  assign deq         = v_o & ready_and_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (enq) wr_ptr_r <= ~wr_ptr_r;
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      if (enq & ~deq) begin
        empty_r <= 1'b0;
        full_r  <= ~empty_r;
      end else if (deq & ~enq) begin
        full_r  <= 1'b0;
        empty_r <= ~full_r;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_ver_link_retime_chain.sv
// Multi-channel bidirectional vertical link retimer with occupancy tracking.
// Define BSG_VER_CHAIN_PERF_EN to add saturating per-channel/direction stall counters.
module bsg_manycore_ver_link_retime_chain
  import bsg_ver_chain_pkg::*;
  #(parameter int width_p      = 64,
    parameter int num_ch_p     = 2,
    parameter int num_stages_p = 2,
    localparam int occ_w_lp    = occ_width(num_stages_p))
  (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_ch_p-1:0]                ns_v_i,
    input  logic [num_ch_p-1:0][width_p-1:0]   ns_data_i,
    output logic [num_ch_p-1:0]                ns_ready_and_o,
    output logic [num_ch_p-1:0]                ns_v_o,
    output logic [num_ch_p-1:0][width_p-1:0]   ns_data_o,
    input  logic [num_ch_p-1:0]                ns_ready_and_i,
    input  logic [num_ch_p-1:0]                sn_v_i,
    input  logic [num_ch_p-1:0][width_p-1:0]   sn_data_i,
    output logic [num_ch_p-1:0]                sn_ready_and_o,
    output logic [num_ch_p-1:0]                sn_v_o,
    output logic [num_ch_p-1:0][width_p-1:0]   sn_data_o,
    input  logic [num_ch_p-1:0]                sn_ready_and_i,
    output logic [num_ch_p-1:0][1:0][occ_w_lp-1:0] occ_o,
`ifdef BSG_VER_CHAIN_PERF_EN
    output logic [num_ch_p-1:0][1:0][stall_cnt_width_gp-1:0] stall_cnt_o,
`endif
    output logic                               idle_o
  );

  logic [num_ch_p-1:0][1:0]              v_in, ready_out, v_out, ready_in;
  logic [num_ch_p-1:0][1:0][width_p-1:0] data_in, data_out;

  for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
    assign v_in[c][e_dir_ns]     = ns_v_i[c];
    assign data_in[c][e_dir_ns]  = ns_data_i[c];
    assign ready_in[c][e_dir_ns] = ns_ready_and_i[c];
    assign ns_ready_and_o[c]     = ready_out[c][e_dir_ns];
    assign ns_v_o[c]             = v_out[c][e_dir_ns];
    assign ns_data_o[c]          = data_out[c][e_dir_ns];

    assign v_in[c][e_dir_sn]     = sn_v_i[c];
    assign data_in[c][e_dir_sn]  = sn_data_i[c];
    assign ready_in[c][e_dir_sn] = sn_ready_and_i[c];
    assign sn_ready_and_o[c]     = ready_out[c][e_dir_sn];
    assign sn_v_o[c]             = v_out[c][e_dir_sn];
    assign sn_data_o[c]          = data_out[c][e_dir_sn];

    for (genvar d = 0; d < 2; d++) begin : g_dir
      logic [occ_w_lp-1:0] occ_q;

      if (num_stages_p == 0) begin : g_pass
        assign v_out[c][d]     = v_in[c][d];
        assign data_out[c][d]  = data_in[c][d];
        assign ready_out[c][d] = ready_in[c][d];
        assign occ_q           = '0;
      end else begin : g_chain
        logic [num_stages_p:0]              v_s, ready_s;
        logic [num_stages_p:0][width_p-1:0] data_s;
        logic                               in_hs, out_hs;

        assign v_s[0]                  = v_in[c][d];
        assign data_s[0]               = data_in[c][d];
        assign ready_out[c][d]         = ready_s[0];
        assign v_out[c][d]             = v_s[num_stages_p];
        assign data_out[c][d]          = data_s[num_stages_p];
        assign ready_s[num_stages_p]   = ready_in[c][d];

        for (genvar k = 0; k < num_stages_p; k++) begin : g_stage
          bsg_ver_chain_stage #(.width_p(width_p)) stage (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .v_i         (v_s[k]),
            .data_i      (data_s[k]),
            .ready_and_o (ready_s[k]),
            .v_o         (v_s[k+1]),
            .data_o      (data_s[k+1]),
            .ready_and_i (ready_s[k+1])
          );
        end

        assign in_hs  = v_in[c][d] & ready_out[c][d];
        assign out_hs = v_out[c][d] & ready_in[c][d];

        // Capacity bounds the count, so it cannot overflow or underflow.
        always_ff @(posedge clk_i) begin
          if (!reset_n_i)
            occ_q <= '0;
          else if (in_hs & ~out_hs)
            occ_q <= occ_q + occ_w_lp'(1);
          else if (~in_hs & out_hs)
            occ_q <= occ_q - occ_w_lp'(1);
        end
      end

      assign occ_o[c][d] = reset_n_i ? occ_q : '0;

`ifdef BSG_VER_CHAIN_PERF_EN
      logic [stall_cnt_width_gp-1:0] stall_cnt_r;

      always_ff @(posedge clk_i) begin
        if (!reset_n_i)
          stall_cnt_r <= '0;
        else if (v_out[c][d] & ~ready_in[c][d] & ~(&stall_cnt_r))
          stall_cnt_r <= stall_cnt_r + stall_cnt_width_gp'(1);
      end

      assign stall_cnt_o[c][d] = reset_n_i ? stall_cnt_r : '0;
`endif
    end
  end

  assign idle_o = (occ_o == '0);

endmodule

// File: tb/tb_bsg_manycore_ver_link_retime_chain.sv
// Directed self-checking bench for bsg_manycore_ver_link_retime_chain (2 channels, 2 stages).
module tb_bsg_manycore_ver_link_retime_chain;

  localparam int width_lp      = 16;
  localparam int num_ch_lp     = 2;
  localparam int num_stages_lp = 2;
  localparam int occ_w_lp      = 3;

  logic clk, reset_n;
  logic [num_ch_lp-1:0]               ns_v_i, ns_ready_and_o, ns_v_o, ns_ready_and_i;
  logic [num_ch_lp-1:0]               sn_v_i, sn_ready_and_o, sn_v_o, sn_ready_and_i;
  logic [num_ch_lp-1:0][width_lp-1:0] ns_data_i, ns_data_o, sn_data_i, sn_data_o;
  logic [num_ch_lp-1:0][1:0][occ_w_lp-1:0] occ_o;
  logic idle_o;
`ifdef BSG_VER_CHAIN_PERF_EN
  logic [num_ch_lp-1:0][1:0][31:0] stall_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  bsg_manycore_ver_link_retime_chain #(
    .width_p(width_lp), .num_ch_p(num_ch_lp), .num_stages_p(num_stages_lp)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .ns_v_i(ns_v_i), .ns_data_i(ns_data_i), .ns_ready_and_o(ns_ready_and_o),
    .ns_v_o(ns_v_o), .ns_data_o(ns_data_o), .ns_ready_and_i(ns_ready_and_i),
    .sn_v_i(sn_v_i), .sn_data_i(sn_data_i), .sn_ready_and_o(sn_ready_and_o),
    .sn_v_o(sn_v_o), .sn_data_o(sn_data_o), .sn_ready_and_i(sn_ready_and_i),
    .occ_o(occ_o),
`ifdef BSG_VER_CHAIN_PERF_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .idle_o(idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input bit is_sn, input logic v,
                               input logic [width_lp-1:0] data, input logic rdy);
    if (!is_sn) begin
      ns_v_i[ch] = v; ns_data_i[ch] = data; ns_ready_and_i[ch] = rdy;
    end else begin
      sn_v_i[ch] = v; sn_data_i[ch] = data; sn_ready_and_i[ch] = rdy;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic exp_v;
    reset_n = 1'b0;
    ns_v_i = '0; sn_v_i = '0; ns_data_i = '0; sn_data_i = '0;
    ns_ready_and_i = '1; sn_ready_and_i = '1;

    // Reset held 3 cycles while a word is offered
    applyStimulus(0, 0, 1'b1, 16'h0011, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ns_rdy", 32'(ns_ready_and_o), 32'h0);
      checkOutput("rst_sn_rdy", 32'(sn_ready_and_o), 32'h0);
      checkOutput("rst_ns_v", 32'(ns_v_o), 32'h0);
      checkOutput("rst_idle", 32'(idle_o), 32'h1);
      checkOutput("rst_occ", 32'(occ_o), 32'h0);
    end
    applyStimulus(0, 0, 1'b0, 16'h0000, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ns_rdy", 32'(ns_ready_and_o), 32'h3);
    checkOutput("post_rst_sn_rdy", 32'(sn_ready_and_o), 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_word", 32'(ns_v_o), 32'h0);
    end

    // Latency of num_stages_lp cycles
    applyStimulus(0, 0, 1'b1, 16'h00A5, 1'b1);
    @(negedge clk);
    applyStimulus(0, 0, 1'b0, 16'h0000, 1'b1);
    checkOutput("lat_t1_v", 32'(ns_v_o[0]), 32'h0);
    checkOutput("lat_t1_occ", 32'(occ_o[0][0]), 32'h1);
    checkOutput("lat_t1_idle", 32'(idle_o), 32'h0);
    @(negedge clk);
    checkOutput("lat_t2_v", 32'(ns_v_o[0]), 32'h1);
    checkOutput("lat_t2_data", 32'(ns_data_o[0]), 32'h00A5);
    @(negedge clk);
    checkOutput("lat_done_v", 32'(ns_v_o[0]), 32'h0);
    checkOutput("lat_done_idle", 32'(idle_o), 32'h1);
    checkOutput("lat_done_occ", 32'(occ_o[0][0]), 32'h0);

    // Fill against a stalled sink: only 4 words fit
    for (int w = 1; w <= 5; w++) begin
      applyStimulus(0, 0, 1'b1, 16'(w), 1'b0);
      checkOutput("full_rdy", 32'(ns_ready_and_o[0]), 32'(w <= 4));
      @(negedge clk);
    end
    applyStimulus(0, 0, 1'b0, 16'h0000, 1'b0);
    checkOutput("full_occ", 32'(occ_o[0][0]), 32'h4);
    checkOutput("full_rdy_low", 32'(ns_ready_and_o[0]), 32'h0);
    applyStimulus(0, 0, 1'b0, 16'h0000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_v", 32'(ns_v_o[0]), 32'h1);
      checkOutput("drain_data", 32'(ns_data_o[0]), 32'(k));
      @(negedge clk);
    end
    checkOutput("drain_empty_v", 32'(ns_v_o[0]), 32'h0);
    checkOutput("drain_empty_occ", 32'(occ_o[0][0]), 32'h0);

    // Streams on ns ch0 and sn ch0 while sn ch1 stalls
    for (int cyc = 0; cyc < 106; cyc++) begin
      exp_v = (cyc >= 2) && (cyc < 102);
      checkOutput("ind_ns_v", 32'(ns_v_o[0]), 32'(exp_v));
      checkOutput("ind_sn_v", 32'(sn_v_o[0]), 32'(exp_v));
      if (exp_v) begin
        checkOutput("ind_ns_data", 32'(ns_data_o[0]), 32'h1000 + 32'(cyc - 2));
        checkOutput("ind_sn_data", 32'(sn_data_o[0]), 32'h2000 + 32'(cyc - 2));
      end
      applyStimulus(0, 0, cyc < 100, 16'h1000 + 16'(cyc), 1'b1);
      applyStimulus(0, 1, cyc < 100, 16'h2000 + 16'(cyc), 1'b1);
      applyStimulus(1, 1, 1'b1, 16'h3000 + 16'(cyc), 1'b0);
      @(negedge clk);
    end
    checkOutput("ind_stall_occ", 32'(occ_o[1][1]), 32'h4);
    checkOutput("ind_stall_rdy", 32'(sn_ready_and_o[1]), 32'h0);
    checkOutput("ind_stall_head", 32'(sn_data_o[1]), 32'h3000);
    checkOutput("ind_ns_occ", 32'(occ_o[0][0]), 32'h0);
    checkOutput("ind_other_occ", 32'(occ_o[1][0]), 32'h0);
    applyStimulus(1, 1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(0, 0, 1'b0, 16'h0000, 1'b1);
    applyStimulus(0, 1, 1'b0, 16'h0000, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("ind_idle", 32'(idle_o), 32'h1);

    // Reset pulse drops three in-flight words
    for (int w = 0; w < 3; w++) begin
      applyStimulus(0, 0, 1'b1, 16'h0051 + 16'(w), 1'b0);
      @(negedge clk);
    end
    applyStimulus(0, 0, 1'b0, 16'h0000, 1'b0);
    checkOutput("mid_occ_pre", 32'(occ_o[0][0]), 32'h3);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_occ_in_rst", 32'(occ_o), 32'h0);
    reset_n = 1'b1;
    checkOutput("mid_occ_post", 32'(occ_o), 32'h0);
    checkOutput("mid_idle_post", 32'(idle_o), 32'h1);
    applyStimulus(0, 0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("mid_no_word", 32'(ns_v_o[0]), 32'h0);
    end

`ifdef BSG_VER_CHAIN_PERF_EN
    // Stall counting and saturation on ns ch1
    applyStimulus(1, 0, 1'b1, 16'h00C3, 1'b0);
    @(negedge clk);
    applyStimulus(1, 0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("perf_v", 32'(ns_v_o[1]), 32'h1);
    checkOutput("perf_cnt0", stall_cnt_o[1][0], 32'h0);
    repeat (10) @(negedge clk);
    checkOutput("perf_cnt10", stall_cnt_o[1][0], 32'd10);
    force dut.g_ch[1].g_dir[0].stall_cnt_r = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.g_ch[1].g_dir[0].stall_cnt_r;
    repeat (5) @(negedge clk);
    checkOutput("perf_sat", stall_cnt_o[1][0], 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
